// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache request protocol: serves dcache word
// reads/writes and icache word reads from a word-addressed backing store with
// a fixed programmable latency, alternating between the caches when both ask.
// Completion is a single-cycle low pulse on the requester's wait line.
module cache_mem_responder #(
    parameter int unsigned LAT        = 2,
    parameter int unsigned AW         = 10,
    parameter int unsigned RESP_CNT_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic SRV_I = 1'b0;
    localparam logic SRV_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t                r_state;
    logic [RESP_CNT_W-1:0] r_cnt;
    logic [AW-1:0]         r_idx;
    logic                  r_wr;
    logic [31:0]           r_data;
    logic                  r_last;
    logic [31:0]           r_mem [DEPTH];

    logic          w_d_req;
    logic          w_i_req;
    logic [AW-1:0] w_d_idx;
    logic [AW-1:0] w_i_idx;
    logic          w_d_done;
    logic          w_i_done;
    logic [31:0]   w_rdata;
    logic          w_unused_addr_bits;

    // Request decode; a write wins when dREN and dWEN are both high
    assign w_d_req  = dREN | dWEN;
    assign w_i_req  = iREN;
    assign w_d_idx  = daddr[AW+1:2];
    assign w_i_idx  = iaddr[AW+1:2];
    assign w_unused_addr_bits = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0]};

    // Completion cycle: counter expired and the requester is still asking; reset suppresses it
    assign w_d_done = !RST && (r_state == D_ACC) && (r_cnt == '0) && w_d_req;
    assign w_i_done = !RST && (r_state == I_ACC) && (r_cnt == '0) && w_i_req;
    assign w_rdata  = r_mem[r_idx];

    assign dwait = !w_d_done;
    assign iwait = !w_i_done;
    assign dload = (w_d_done && !r_wr) ? w_rdata : 32'h0;
    assign iload = w_i_done ? w_rdata : 32'h0;

    // Access sequencer: accept, count down the latency, complete or abort, then one turnaround cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_data  <= 32'h0;
            r_last  <= SRV_I;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_d_req && (!w_i_req || r_last == SRV_I)) begin
                        r_state <= D_ACC;
                        r_idx   <= w_d_idx;
                        r_wr    <= dWEN;
                        r_data  <= dstore;
                        r_cnt   <= RESP_CNT_W'(LAT - 1);
                    end else if (w_i_req) begin
                        r_state <= I_ACC;
                        r_idx   <= w_i_idx;
                        r_wr    <= 1'b0;
                        r_cnt   <= RESP_CNT_W'(LAT - 1);
                    end
                end
                D_ACC: begin
                    if (!w_d_req) begin
                        r_state <= TURN;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - RESP_CNT_W'(1);
                    end else begin
                        r_last  <= SRV_D;
                        r_state <= TURN;
                    end
                end
                I_ACC: begin
                    if (!w_i_req) begin
                        r_state <= TURN;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - RESP_CNT_W'(1);
                    end else begin
                        r_last  <= SRV_I;
                        r_state <= TURN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Backing store: the latched write data lands at the end of the completion cycle
    always_ff @(posedge CLK) begin
        if (w_d_done && r_wr) begin
            r_mem[r_idx] <= r_data;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed protocol scenarios plus randomized
// single-requester traffic checked against a word-array model of the store.
module tb_cache_mem_responder;

    localparam int unsigned LAT   = 2;
    localparam int unsigned LAT3  = 3;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;

    logic        k_rst, k_iren, k_dren, k_dwen;
    logic [31:0] k_iaddr, k_daddr, k_dstore;
    logic        k_iwait, k_dwait;
    logic [31:0] k_iload, k_dload;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_valid [DEPTH];

    logic [31:0] rd, rd2, a, dat, exp_rd;
    int          lat, lat2, dc0, dc1, k_srv, gap;
    int          srv [3];
    bit          is_i, wr;
    int unsigned idx;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    cache_mem_responder #(.LAT(LAT), .AW(AW), .RESP_CNT_W(4)) u_dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    cache_mem_responder #(.LAT(LAT3), .AW(AW), .RESP_CNT_W(4)) u_dut3 (
        .CLK(CLK), .RST(k_rst),
        .iREN(k_iren), .iaddr(k_iaddr), .iwait(k_iwait), .iload(k_iload),
        .dREN(k_dren), .dWEN(k_dwen), .daddr(k_daddr), .dstore(k_dstore),
        .dwait(k_dwait), .dload(k_dload)
    );

    function automatic int unsigned widx(input logic [31:0] addr);
        return (addr >> 2) % DEPTH;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Raise a request and wait for its completion cycle; returns there
    task automatic access(input bit ii, input bit w, input logic [31:0] ad, input logic [31:0] dt,
                          output logic [31:0] r, output int l, output int dcy);
        bit done;
        done = 1'b0;
        l = 0; r = 32'h0; dcy = 0;
        if (ii) begin
            iREN = 1'b1; iaddr = ad;
        end else begin
            dREN = !w; dWEN = w; daddr = ad; dstore = dt;
        end
        for (int c = 0; c < 40 && !done; c++) begin
            #2;
            check("other_wait_high", 32'(ii ? dwait : iwait), 32'd1);
            if ((ii ? iwait : dwait) === 1'b0) begin
                r = ii ? iload : dload;
                dcy = cyc;
                done = 1'b1;
            end else begin
                check("load_zero_while_wait", ii ? iload : dload, 32'h0);
                tick();
                l++;
            end
        end
        if (!done) check("access_timeout", 32'(l), 32'(LAT));
    endtask

    // Complete standalone transaction; returns in the next IDLE cycle
    task automatic op(input bit ii, input bit w, input logic [31:0] ad, input logic [31:0] dt,
                      output logic [31:0] r, output int l);
        int dcy;
        access(ii, w, ad, dt, r, l, dcy);
        if (!ii && w) begin
            ref_mem[widx(ad)]   = dt;
            ref_valid[widx(ad)] = 1'b1;
        end
        tick();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        #2;
        check("wait_single_cycle", 32'(ii ? iwait : dwait), 32'd1);
        tick();
    endtask

    // Standalone dcache transaction on the LAT=3 instance
    task automatic acc3(input bit w, input logic [31:0] ad, input logic [31:0] dt,
                        output logic [31:0] r, output int l);
        bit done;
        done = 1'b0; l = 0; r = 32'h0;
        k_dren = !w; k_dwen = w; k_daddr = ad; k_dstore = dt;
        for (int c = 0; c < 40 && !done; c++) begin
            #2;
            if (k_dwait === 1'b0) begin
                r = k_dload;
                done = 1'b1;
            end else begin
                tick();
                l++;
            end
        end
        if (!done) check("acc3_timeout", 32'(l), 32'(LAT3));
        tick();
        k_dren = 1'b0; k_dwen = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        k_rst = 1'b1; k_iren = 1'b0; k_dren = 1'b0; k_dwen = 1'b0;
        k_iaddr = 32'h0; k_daddr = 32'h0; k_dstore = 32'h0;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            #2;
            check("rst_iwait", 32'(iwait), 32'd1);
            check("rst_dwait", 32'(dwait), 32'd1);
            check("rst_iload", iload, 32'h0);
            check("rst_dload", dload, 32'h0);
        end
        RST = 1'b0; k_rst = 1'b0;
        tick();

        // Write then read of the same word, low address bits ignored
        op(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, rd, lat);
        check("wr_latency", 32'(lat), 32'(LAT));
        op(1'b0, 1'b0, 32'h0000_0042, 32'h0, rd, lat);
        check("rd_latency", 32'(lat), 32'(LAT));
        check("rd_after_wr", rd, 32'hDEAD_BEEF);

        // Two-word block fill, second request raised right after the first completion
        op(1'b0, 1'b1, 32'h0000_0080, 32'h1111_1111, rd, lat);
        op(1'b0, 1'b1, 32'h0000_0084, 32'h2222_2222, rd, lat);
        access(1'b0, 1'b0, 32'h0000_0080, 32'h0, rd, lat, dc0);
        tick();
        access(1'b0, 1'b0, 32'h0000_0084, 32'h0, rd2, lat2, dc1);
        tick();
        dREN = 1'b0;
        tick();
        check("fill_word0", rd, 32'h1111_1111);
        check("fill_word1", rd2, 32'h2222_2222);
        check("fill_spacing", 32'(dc1 - dc0), 32'(LAT + 2));

        // Address wrap modulo store depth, and icache sees dcache-written data
        op(1'b0, 1'b1, 32'h0000_1004, 32'h5A5A_5A5A, rd, lat);
        op(1'b0, 1'b0, 32'h0000_0004, 32'h0, rd, lat);
        check("wrap_read", rd, 32'h5A5A_5A5A);
        op(1'b1, 1'b0, 32'h0000_0040, 32'h0, rd, lat);
        check("icache_latency", 32'(lat), 32'(LAT));
        check("icache_sees_dwrite", rd, 32'hDEAD_BEEF);

        // Reset landing on the completion cycle of a write
        dWEN = 1'b1; daddr = 32'h0000_0004; dstore = 32'hBAD0_BAD0;
        #2; check("midrst_wait_t0", 32'(dwait), 32'd1);
        tick();
        #2; check("midrst_wait_t1", 32'(dwait), 32'd1);
        tick();
        RST = 1'b1;
        #2; check("midrst_wait_t2", 32'(dwait), 32'd1);
        check("midrst_dload", dload, 32'h0);
        tick();
        RST = 1'b0; dWEN = 1'b0;
        #2; check("midrst_wait_t3", 32'(dwait), 32'd1);
        tick();

        // Both caches requesting after reset: dcache first, then alternate
        srv[0] = -1; srv[1] = -1; srv[2] = -1;
        k_srv = 0;
        dREN = 1'b1; daddr = 32'h0000_0040;
        iREN = 1'b1; iaddr = 32'h0000_0084;
        for (int c = 0; c < 40 && k_srv < 3; c++) begin
            #2;
            check("arb_exclusive", 32'(iwait | dwait), 32'd1);
            if (dwait === 1'b0) begin
                srv[k_srv] = 1;
                k_srv++;
                check("arb_dload", dload, 32'hDEAD_BEEF);
            end else if (iwait === 1'b0) begin
                srv[k_srv] = 0;
                k_srv++;
                check("arb_iload", iload, 32'h2222_2222);
            end
            tick();
        end
        dREN = 1'b0; iREN = 1'b0;
        tick(); tick();
        check("arb_first_d", 32'(srv[0]), 32'd1);
        check("arb_second_i", 32'(srv[1]), 32'd0);
        check("arb_third_d", 32'(srv[2]), 32'd1);

        // Word hit by the reset-dropped write still holds its earlier value
        op(1'b0, 1'b0, 32'h0000_0004, 32'h0, rd, lat);
        check("midrst_store_kept", rd, 32'h5A5A_5A5A);

        // Abort on the LAT=3 instance: request dropped after one cycle
        acc3(1'b1, 32'h0000_0100, 32'h0BAD_C0DE, rd, lat);
        check("lat3_wr_latency", 32'(lat), 32'(LAT3));
        k_dwen = 1'b1; k_daddr = 32'h0000_0100; k_dstore = 32'hCAFE_F00D;
        #2; check("abort_wait_accept", 32'(k_dwait), 32'd1);
        tick();
        k_dwen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #2;
            check("abort_wait_high", 32'(k_dwait), 32'd1);
            tick();
        end
        acc3(1'b0, 32'h0000_0100, 32'h0, rd, lat);
        check("lat3_rd_latency", 32'(lat), 32'(LAT3));
        check("abort_no_write", rd, 32'h0BAD_C0DE);

        // Randomized single-requester traffic against the word-array model
        for (int n = 0; n < 40; n++) begin
            idx  = 32'h200 + $urandom_range(0, 15);
            is_i = 1'($urandom_range(0, 1));
            wr   = !is_i && ($urandom_range(0, 1) == 1);
            if (!ref_valid[idx]) begin
                is_i = 1'b0;
                wr   = 1'b1;
            end
            a      = ($urandom & 32'hFFFF_F003) | (idx << 2);
            dat    = $urandom;
            exp_rd = ref_mem[widx(a)];
            op(is_i, wr, a, dat, rd, lat);
            check("rnd_latency", 32'(lat), 32'(LAT));
            if (!wr) check("rnd_read_data", rd, exp_rd);
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
